seg7_rx_bcd: RTL and testbench
==============================

# seg7_rx_bcd

Seven-segment receive decoder: the inverse of the `hc4511` BCD-to-segment driver. It samples an active-high, common-cathode segment bus, filters it for glitches, and decodes accepted patterns back to BCD 0–9. It flags blank and illegal patterns, counts accepted digits, and optionally checks that digits arrive in mod-10 up-count order. It sits on the segment bus beside the display and acts as a monitor and loopback checker for the HC161 + `hc4511` counter chain.

## Interface
- `STABLE_CYC`, default 4: consecutive identical samples required before a pattern is accepted; legal range 1–15.
- `CP`, input, 1: clock, rising edge.
- `MRN`, input, 1: reset, asynchronous, active-low.
- `Seg`, input, 8: segment bus. Bit 0 = a … bit 6 = g, bit 7 = dp; dp is ignored.
- `CLR`, input, 1: synchronous clear of the sticky flags, `CNT` and the sequence history.
- `BCD`, output, 4: last accepted digit.
- `VALID`, output, 1: one-cycle pulse on each newly accepted digit.
- `BLANK`, output, 1: level; the last accepted pattern is all-off.
- `ERR`, output, 1: sticky; an illegal pattern was accepted.
- `SEQ_ERR`, output, 1: sticky; an out-of-order digit was accepted.
- `CNT`, output, 8: number of accepted digits, wraps 255→0.

## Operation
- Legal patterns on `Seg[6:0]`:
  - 0 = 0x3F
  - 1 = 0x06
  - 2 = 0x5B
  - 3 = 0x4F
  - 4 = 0x66
  - 5 = 0x6D
  - 6 = 0x7C or 0x7D
  - 7 = 0x07
  - 8 = 0x7F
  - 9 = 0x67 or 0x6F
  - blank = 0x00
  - Any other value is illegal.
- Input path:
  - `Seg[6:0]` is registered into `smp` every cycle.
  - `stb` counts the cycles `smp` has equalled its previous value. It saturates at `STABLE_CYC` and restarts at 0 on any difference.
- Accept event: `stb` reaches `STABLE_CYC` **and** `smp` differs from the last accepted pattern `acc`. Then `acc <= smp` and the pattern is classified:
  - **Digit:**
    - `BCD` is updated.
    - `VALID` pulses for one cycle.
    - `BLANK` is cleared.
    - `CNT` increments.
  - **Blank:**
    - `BLANK` is set.
    - `BCD`, `VALID` and `CNT` are unchanged.
    - The sequence history is broken.
  - **Illegal:**
    - `ERR` is set.
    - `BCD` and `BLANK` hold.
    - The sequence history is broken.
- A pattern that holds after acceptance is not re-accepted. A return to the same digit after another pattern has been accepted is a new accept.
- Sequence FSM:
  - **NOHIST**: no reference digit. A digit accept moves to HIST; no check is made.
  - **HIST**: a digit accept checks new == (prev + 1) mod 10. A mismatch sets `SEQ_ERR`; the FSM stays in HIST and the new digit becomes the reference.
  - A blank or illegal accept, or `CLR`, returns the FSM to NOHIST.
- `CLR` clears `ERR`, `SEQ_ERR` and `CNT` and sets the FSM to NOHIST. `BCD`, `BLANK`, `acc` and the filter are not affected.
- Simultaneous accept and `CLR`: the accept updates `BCD`, `BLANK` and `VALID`. `CLR` wins on `ERR`, `SEQ_ERR`, `CNT` and the FSM.
- Reset values: `BCD` = 0, `VALID` = 0, `BLANK` = 1, `ERR` = 0, `SEQ_ERR` = 0, `CNT` = 0, `stb` = 0, `acc` = 0x00, FSM = NOHIST.

## Timing
- A change on `Seg` settling before edge k is sampled at edge k. An accept is registered at edge k+`STABLE_CYC`.
- Latency from `Seg` change to `VALID` high is `STABLE_CYC`+1 edges.
- Patterns held fewer than `STABLE_CYC`+1 cycles are filtered out with no effect on any output.
- All outputs are registered; there are no combinational paths from input to output.
- `MRN` assertion mid-stream clears everything asynchronously. After release, the first accept needs a full `STABLE_CYC` window.

## Configuration
- `SEG7RX_SEQCHK_EN`:
  - **Defined:** the sequence FSM and `SEQ_ERR` logic are compiled in.
  - **Undefined:** the FSM is removed and `SEQ_ERR` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `seg7_pkg` holds:
  - the segment pattern constants `SEG_0`…`SEG_9`, `SEG_6_ALT`, `SEG_9_ALT` and `SEG_BLANK`;
  - the sequence FSM state typedef.
- One sub-module, `seg7_glitch_filter`: the `smp`/`stb` register pair plus the stable flag, parameterised by `STABLE_CYC`.
- Classification and the FSM live in the top module.

## Test plan
- Reset, then hold `Seg` = 0x3F for 10 cycles → `VALID` pulses exactly once at edge 5, `BCD` = 0, `CNT` = 1, `BLANK` = 0.
- Drive 0x06 for 3 cycles, then back to 0x3F (`STABLE_CYC` = 4) → no `VALID`, `BCD` stays 0, `CNT` unchanged.
- Count through 0x3F, 0x06, 0x5B … 0x6F, 0x3F, holding each 8 cycles; 6 and 9 use the alternate codes → `BCD` sequence 0..9,0, 11 `VALID` pulses, `CNT` = 11, `SEQ_ERR` = 0.
- Accept 3 (0x4F) then 5 (0x6D) → `SEQ_ERR` = 1 and remains 1 after a further legal 6; `CLR` pulse → `SEQ_ERR` = 0, `CNT` = 0.
- Accept 0x00, then 0x49 → `BLANK` = 1 then `ERR` = 1, `BCD` holds its last digit. Next accept of 4 after 7 → no `SEQ_ERR`, because the blank/illegal accepts broke the history.
- Assert `MRN` during a stable window → all outputs return to reset values at once. With `SEG7RX_SEQCHK_EN` undefined, rerun the out-of-order case → `SEQ_ERR` stays 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment receive decoder: segment
// pattern constants (bit 0 = a ... bit 6 = g), the sequence FSM state
// type and a pattern classifier.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7C;
  localparam logic [6:0] SEG_6_ALT = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_9_ALT = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_NOHIST,
    ST_HIST
  } seq_state_t;

  typedef enum logic [1:0] {
    PAT_DIGIT,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_kind_t;

  typedef struct packed {
    pat_kind_t  kind;
    logic [3:0] digit;
  } pat_class_t;

  // Map a 7-bit segment pattern to digit / blank / illegal.
  function automatic pat_class_t classify(input logic [6:0] p);
    pat_class_t c;
    c.kind  = PAT_DIGIT;
    c.digit = 4'd0;
    case (p)
      SEG_0:            c.digit = 4'd0;
      SEG_1:            c.digit = 4'd1;
      SEG_2:            c.digit = 4'd2;
      SEG_3:            c.digit = 4'd3;
      SEG_4:            c.digit = 4'd4;
      SEG_5:            c.digit = 4'd5;
      SEG_6, SEG_6_ALT: c.digit = 4'd6;
      SEG_7:            c.digit = 4'd7;
      SEG_8:            c.digit = 4'd8;
      SEG_9, SEG_9_ALT: c.digit = 4'd9;
      SEG_BLANK:        c.kind  = PAT_BLANK;
      default:          c.kind  = PAT_ILLEGAL;
    endcase
    return c;
  endfunction

  // Mod-10 successor used by the order checker.
  function automatic logic [3:0] succ10(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_glitch_filter.sv
// Input sampler and stability counter for the segment bus.
// smp holds the last sample; stb counts consecutive repeats of it and
// saturates at STABLE_CYC. 'stable' looks at the count being written on
// this edge, so an accept lands on the same edge the count reaches
// STABLE_CYC (STABLE_CYC edges after the new value was first sampled).
module seg7_glitch_filter #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] din,
  output logic [6:0] smp,
  output logic       stable
);

  localparam logic [3:0] LIM = 4'(STABLE_CYC);

  logic [3:0] stb;
  logic [3:0] stb_nxt;

  // Next repeat count: saturating increment on a match, restart on change.
  always_comb begin
    stb_nxt = 4'd0;
    if (din == smp)
      stb_nxt = (stb == LIM) ? LIM : stb + 4'd1;
  end

  assign stable = (stb_nxt == LIM);

  // Sample register and repeat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= 7'h00;
      stb <= 4'd0;
    end else begin
      smp <= din;
      stb <= stb_nxt;
    end
  end

endmodule

// File: rtl/seg7_rx_bcd.sv
// Seven-segment receive decoder: filters the segment bus, decodes
// accepted patterns back to BCD, flags blank/illegal patterns, counts
// digits and (with SEG7RX_SEQCHK_EN defined) checks mod-10 up-count order.
// Without SEG7RX_SEQCHK_EN the order checker is absent and SEQ_ERR is 0.
module seg7_rx_bcd
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       CP,
  input  logic       MRN,
  input  logic [7:0] Seg,
  input  logic       CLR,
  output logic [3:0] BCD,
  output logic       VALID,
  output logic       BLANK,
  output logic       ERR,
  output logic       SEQ_ERR,
  output logic [7:0] CNT
);

  logic [6:0] smp;
  logic       stable;
  logic [6:0] acc;
  logic       accept;
  pat_class_t cls;
  logic       dp_unused;

  // Decimal point carries no digit information.
  assign dp_unused = Seg[7];

  seg7_glitch_filter #(.STABLE_CYC(STABLE_CYC)) u_filt (
    .clk    (CP),
    .rst_n  (MRN),
    .din    (Seg[6:0]),
    .smp    (smp),
    .stable (stable)
  );

  // While stable, smp equals the bus; a held pattern is accepted only once.
  assign accept = stable && (smp != acc);
  assign cls    = classify(smp);

  // Accepted pattern, digit/blank outputs, sticky error and digit count.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      acc   <= SEG_BLANK;
      BCD   <= 4'd0;
      VALID <= 1'b0;
      BLANK <= 1'b1;
      ERR   <= 1'b0;
      CNT   <= 8'd0;
    end else begin
      VALID <= 1'b0;
      if (accept) begin
        acc <= smp;
        case (cls.kind)
          PAT_DIGIT: begin
            BCD   <= cls.digit;
            VALID <= 1'b1;
            BLANK <= 1'b0;
          end
          PAT_BLANK: BLANK <= 1'b1;
          default: ;
        endcase
      end
      // CLR outranks a coincident accept for the sticky flag and count.
      if (CLR) begin
        ERR <= 1'b0;
        CNT <= 8'd0;
      end else if (accept) begin
        if (cls.kind == PAT_ILLEGAL) ERR <= 1'b1;
        if (cls.kind == PAT_DIGIT)   CNT <= CNT + 8'd1;
      end
    end
  end

`ifdef SEG7RX_SEQCHK_EN
  seq_state_t state;
  seq_state_t state_nxt;
  logic [3:0] prev;
  logic       seq_bad;
  logic       seq_err_q;

  // Sequence state register.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) state <= ST_NOHIST;
    else      state <= state_nxt;
  end

  // Next state and order check; blank/illegal accepts or CLR drop history.
  always_comb begin
    state_nxt = state;
    seq_bad   = 1'b0;
    if (CLR) begin
      state_nxt = ST_NOHIST;
    end else if (accept) begin
      if (cls.kind == PAT_DIGIT) begin
        seq_bad   = (state == ST_HIST) && (cls.digit != succ10(prev));
        state_nxt = ST_HIST;
      end else begin
        state_nxt = ST_NOHIST;
      end
    end
  end

  // Reference digit and sticky order-error flag.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      prev      <= 4'd0;
      seq_err_q <= 1'b0;
    end else begin
      if (accept && cls.kind == PAT_DIGIT) prev <= cls.digit;
      if (CLR)          seq_err_q <= 1'b0;
      else if (seq_bad) seq_err_q <= 1'b1;
    end
  end

  assign SEQ_ERR = seq_err_q;
`else
  assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_rx_bcd.sv
// Self-checking bench for seg7_rx_bcd: directed scenarios plus a random
// run, compared cycle by cycle against a window-based reference model.
module tb_seg7_rx_bcd;

  localparam int S = 4;
`ifdef SEG7RX_SEQCHK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic       CP = 1'b0;
  logic       MRN;
  logic       CLR;
  logic [7:0] Seg;
  logic [3:0] BCD;
  logic       VALID, BLANK, ERR, SEQ_ERR;
  logic [7:0] CNT;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_rx_bcd #(.STABLE_CYC(S)) dut (
    .CP(CP), .MRN(MRN), .Seg(Seg), .CLR(CLR),
    .BCD(BCD), .VALID(VALID), .BLANK(BLANK), .ERR(ERR),
    .SEQ_ERR(SEQ_ERR), .CNT(CNT)
  );

  initial forever #5 CP = ~CP;

  // ---------------- reference model ----------------
  // Digit value of a pattern, 10 = blank, 11 = illegal.
  function automatic int dec(input logic [6:0] p);
    case (p)
      7'h3F: return 0;
      7'h06: return 1;
      7'h5B: return 2;
      7'h4F: return 3;
      7'h66: return 4;
      7'h6D: return 5;
      7'h7C, 7'h7D: return 6;
      7'h07: return 7;
      7'h7F: return 8;
      7'h67, 7'h6F: return 9;
      7'h00: return 10;
      default: return 11;
    endcase
  endfunction

  function automatic logic [7:0] code(input int d, input bit alt);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return alt ? 8'h7D : 8'h7C;
      7: return 8'h07; 8: return 8'h7F; default: return alt ? 8'h6F : 8'h67;
    endcase
  endfunction

  logic [6:0] win [0:15];   // past samples, win[0] = most recent
  logic [6:0] m_acc;
  logic [3:0] m_bcd;
  logic       m_valid, m_blank, m_err, m_seq, m_hist;
  logic [7:0] m_cnt;
  int         m_prev;
  logic       m_accept;
  int         m_dec;

  // A pattern is accepted once it has been seen on S+1 consecutive edges
  // and differs from the last accepted one.
  always_comb begin
    m_accept = (Seg[6:0] != m_acc);
    for (int i = 0; i < S; i++)
      if (win[i] != Seg[6:0]) m_accept = 1'b0;
    m_dec = dec(Seg[6:0]);
  end

  always @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      for (int i = 0; i < 16; i++) win[i] <= 7'h00;
      m_acc <= 7'h00; m_bcd <= 4'd0; m_valid <= 1'b0; m_blank <= 1'b1;
      m_err <= 1'b0; m_seq <= 1'b0; m_cnt <= 8'd0; m_hist <= 1'b0; m_prev <= 0;
    end else begin
      for (int i = 0; i < 15; i++) win[i+1] <= win[i];
      win[0]  <= Seg[6:0];
      m_valid <= 1'b0;
      if (m_accept) begin
        m_acc <= Seg[6:0];
        if (m_dec < 10) begin
          m_bcd <= 4'(m_dec); m_valid <= 1'b1; m_blank <= 1'b0;
        end else if (m_dec == 10) m_blank <= 1'b1;
      end
      if (CLR) begin
        m_err <= 1'b0; m_cnt <= 8'd0; m_hist <= 1'b0; m_seq <= 1'b0;
      end else if (m_accept) begin
        if (m_dec < 10) begin
          m_cnt <= m_cnt + 8'd1;
          if (SEQ_ON && m_hist && m_dec != (m_prev + 1) % 10) m_seq <= 1'b1;
          m_hist <= 1'b1;
          m_prev <= m_dec;
        end else begin
          if (m_dec == 11) m_err <= 1'b1;
          m_hist <= 1'b0;
        end
      end
    end
  end

  wire [15:0] obs  = {BCD, VALID, BLANK, ERR, SEQ_ERR, CNT};
  wire [15:0] expv = {m_bcd, m_valid, m_blank, m_err, m_seq, m_cnt};
  localparam logic [15:0] RST_VEC = {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

  // Drive one cycle's inputs at the falling edge; returns at the next one.
  task automatic drive_cycle(input logic [7:0] s, input logic c);
    Seg = s; CLR = c;
    @(posedge CP);
    @(negedge CP);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    MRN = 1'b0; Seg = 8'h00; CLR = 1'b0;
    #12;
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++; $display("FAIL reset_values got %h want %h", obs, RST_VEC);
    end
    @(negedge CP); MRN = 1'b1;
  endtask

  task automatic test_first_accept;
    int pulses = 0, at = 0;
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(8'h3F, 1'b0);
      if (VALID) begin pulses++; at = i; end
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL first_accept cyc %0d got %h want %h", i, obs, expv);
      end
    end
    n_cmp++;
    if (pulses != 1 || at != S + 1 || BCD !== 4'd0 || CNT !== 8'd1 || BLANK !== 1'b0) begin
      n_bad++;
      $display("FAIL first_accept_pulse pulses %0d at %0d bcd %0d cnt %0d blank %b want 1 at %0d bcd 0 cnt 1 blank 0",
               pulses, at, BCD, CNT, BLANK, S + 1);
    end
  endtask

  task automatic test_glitch;
    int pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive_cycle((i < S - 1) ? 8'h06 : 8'h3F, 1'b0);
      if (VALID) pulses++;
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL glitch cyc %0d got %h want %h", i, obs, expv);
      end
    end
    n_cmp++;
    if (pulses != 0 || BCD !== 4'd0 || CNT !== 8'd1) begin
      n_bad++; $display("FAIL glitch_filtered pulses %0d bcd %0d cnt %0d want 0 0 1", pulses, BCD, CNT);
    end
  endtask

  task automatic test_count;
    int got[$];
    @(negedge CP); MRN = 1'b0; Seg = 8'h00;
    @(negedge CP); MRN = 1'b1;
    for (int d = 0; d <= 10; d++)
      for (int c = 0; c < 8; c++) begin
        drive_cycle(code(d % 10, 1'b1), 1'b0);
        if (VALID) got.push_back(int'(BCD));
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL count d %0d cyc %0d got %h want %h", d, c, obs, expv);
        end
      end
    n_cmp++;
    if (got.size() != 11 || CNT !== 8'd11 || SEQ_ERR !== 1'b0) begin
      n_bad++; $display("FAIL count_total pulses %0d cnt %0d seq %b want 11 11 0", got.size(), CNT, SEQ_ERR);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] != i % 10) begin
        n_bad++; $display("FAIL count_bcd idx %0d got %0d want %0d", i, got[i], i % 10);
      end
    end
  endtask

  task automatic test_seq_err;
    drive_cycle(8'h3F, 1'b1);
    for (int c = 0; c < 8; c++) drive_cycle(8'h4F, 1'b0);
    for (int c = 0; c < 8; c++) drive_cycle(8'h6D, 1'b0);
    n_cmp++;
    if (SEQ_ERR !== SEQ_ON || BCD !== 4'd5) begin
      n_bad++; $display("FAIL seq_err_set seq %b bcd %0d want %b 5", SEQ_ERR, BCD, SEQ_ON);
    end
    for (int c = 0; c < 8; c++) drive_cycle(8'h7C, 1'b0);
    n_cmp++;
    if (SEQ_ERR !== SEQ_ON || BCD !== 4'd6 || CNT !== 8'd3) begin
      n_bad++; $display("FAIL seq_err_sticky seq %b bcd %0d cnt %0d want %b 6 3", SEQ_ERR, BCD, CNT, SEQ_ON);
    end
    drive_cycle(8'h7C, 1'b1);
    n_cmp++;
    if (SEQ_ERR !== 1'b0 || CNT !== 8'd0 || BCD !== 4'd6) begin
      n_bad++; $display("FAIL seq_err_clr seq %b cnt %0d bcd %0d want 0 0 6", SEQ_ERR, CNT, BCD);
    end
  endtask

  task automatic test_blank_illegal;
    drive_cycle(8'h7C, 1'b1);
    for (int c = 0; c < 8; c++) drive_cycle(8'h07, 1'b0);
    for (int c = 0; c < 8; c++) drive_cycle(8'h80, 1'b0);  // blank, dp lit
    n_cmp++;
    if (BLANK !== 1'b1 || BCD !== 4'd7 || ERR !== 1'b0) begin
      n_bad++; $display("FAIL blank_accept blank %b bcd %0d err %b want 1 7 0", BLANK, BCD, ERR);
    end
    for (int c = 0; c < 8; c++) drive_cycle(8'h49, 1'b0);
    n_cmp++;
    if (ERR !== 1'b1 || BLANK !== 1'b1 || BCD !== 4'd7 || CNT !== 8'd1) begin
      n_bad++; $display("FAIL illegal_accept err %b blank %b bcd %0d cnt %0d want 1 1 7 1", ERR, BLANK, BCD, CNT);
    end
    for (int c = 0; c < 8; c++) drive_cycle(8'h66, 1'b0);
    n_cmp++;
    if (SEQ_ERR !== 1'b0 || BCD !== 4'd4 || BLANK !== 1'b0 || ERR !== 1'b1) begin
      n_bad++; $display("FAIL history_broken seq %b bcd %0d blank %b err %b want 0 4 0 1", SEQ_ERR, BCD, BLANK, ERR);
    end
  endtask

  task automatic test_mrn_mid;
    int at = 0;
    for (int c = 0; c < 8; c++) drive_cycle(8'h7F, 1'b0);
    drive_cycle(8'h6D, 1'b0);
    drive_cycle(8'h6D, 1'b0);
    #2 MRN = 1'b0;
    #1;
    n_cmp++;
    if (obs !== RST_VEC) begin
      n_bad++; $display("FAIL mrn_async got %h want %h", obs, RST_VEC);
    end
    @(negedge CP); MRN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(8'h6D, 1'b0);
      if (VALID && at == 0) at = i;
      n_cmp++;
      if (obs !== expv) begin
        n_bad++; $display("FAIL mrn_after cyc %0d got %h want %h", i, obs, expv);
      end
    end
    n_cmp++;
    if (at != S + 1) begin
      n_bad++; $display("FAIL mrn_window first valid at %0d want %0d", at, S + 1);
    end
  endtask

  task automatic test_random;
    int nd = 0;
    logic [7:0] s;
    for (int k = 0; k < 150; k++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 55)      begin s = code(nd, 1'($urandom)); nd = (nd + 1) % 10; end
      else if (r < 75) s = code(int'($urandom_range(0, 9)), 1'($urandom));
      else if (r < 85) s = 8'h00;
      else             s = 8'($urandom);
      s[7] = 1'($urandom);
      for (int h = int'($urandom_range(1, 9)); h > 0; h--) begin
        drive_cycle(s, ($urandom_range(0, 39) == 0));
        n_cmp++;
        if (obs !== expv) begin
          n_bad++; $display("FAIL random k %0d seg %h got %h want %h", k, s, obs, expv);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_glitch();
    test_count();
    test_seq_err();
    test_blank_illegal();
    test_mrn_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
